fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage with IF/ID pipeline register for the RV32I core. Holds the program counter, issues one-at-a-time word requests to instruction memory over a valid/ready handshake, and captures each returned instruction into the IF/ID register. The registered instruction and its opcode field drive the decode stage, including the SignExtender's `instIn` and `opcode` inputs. Accepts stall from the hazard unit and PC redirects (taken branch/JAL/JALR) from execute.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `NOP_INST`, 32'h0000_0013, instruction presented on `id_inst` when IF/ID is empty or flushed (`addi x0,x0,0`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_addr` out 32: fetch address, always equal to PC register.
- `imem_rsp_valid` in 1: response valid; at most one per accepted request, earliest the cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `stall` in 1: hold IF/ID contents.
- `redirect_valid` in 1: PC redirect strobe.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `id_valid` out 1: IF/ID holds a real instruction.
- `id_inst` out 32: IF/ID instruction.
- `id_opcode` out 7: `id_inst[6:0]`, registered alongside it.
- `id_pc` out 32: PC of `id_inst`.
- `id_pc_plus4` out 32: `id_pc + 4`, modulo 2^32.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_pc`: PC of the outstanding request.
  - One-entry skid buffer holding instruction and PC.
  - IF/ID register.
  - FSM.
- **Reset values:**
  - `pc = RESET_PC`, state `FETCH`.
  - `id_valid = 0`, `id_inst = NOP_INST`, `id_opcode = 7'b0010011`, `id_pc = 0`, `id_pc_plus4 = 0`.
  - Skid buffer empty.
  - `imem_req_valid` is forced to 0 while `rst` is high.
- **FSM states:**
  - `FETCH`: `imem_req_valid = 1`. On `imem_req_ready`: `req_pc <= pc`, `pc <= pc + 4` (wraps 32'hFFFF_FFFC -> 0), go to `WAIT`.
  - `WAIT`: request outstanding, `imem_req_valid = 0`. On `imem_rsp_valid` with `stall = 0`: load IF/ID (`id_valid = 1`, inst, opcode, `req_pc`, `req_pc + 4`), go to `FETCH`. On `imem_rsp_valid` with `stall = 1`: write the skid buffer, go to `FULL`.
  - `FULL`: `imem_req_valid = 0`. When `stall = 0`: move the skid buffer into IF/ID, go to `FETCH`.
  - `DRAIN`: discards the response of a request that a redirect made stale. `imem_req_valid = 0`. On `imem_rsp_valid`: drop the data, go to `FETCH`.
- **IF/ID update when not stalled and not redirected:**
  - Loads the new instruction if one arrives from `WAIT` or `FULL`.
  - Otherwise takes a bubble (`id_valid = 0`, `id_inst = NOP_INST`, opcode and PCs unchanged).
- **Stall:** `stall = 1` freezes every IF/ID field. Fetching continues until one response sits in the skid buffer.
- **Redirect** has priority over stall and over every FSM action:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - IF/ID is flushed (`id_valid = 0`, `id_inst = NOP_INST`).
  - The skid buffer is emptied.
  - Next state depends on the current state:
    - `FETCH` with `imem_req_ready`: `DRAIN` (the stale request was issued).
    - `FETCH` without `imem_req_ready`: `FETCH`.
    - `WAIT` without response: `DRAIN`.
    - `WAIT` with response the same cycle: response dropped, go to `FETCH`.
    - `FULL`: `FETCH`.
    - `DRAIN` with response: `FETCH`.
    - `DRAIN` without response: `DRAIN`.
  - The PC register holds at most one redirect. A second redirect while in `DRAIN` overwrites `pc`.
- **Reset mid-operation:** all state returns to reset values at once. Any response arriving after reset deasserts while in `FETCH` is ignored.

## Timing
- Request accepted in cycle N with response in N+1: `id_*` is valid in N+2, and the next request is issued in N+2. Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Responses with variable latency are waited for in `WAIT` indefinitely; no timeout.
- Redirect in cycle R: `id_valid = 0` from R+1, and `imem_addr = redirect_pc` from R+1.
- All `id_*` outputs are registers. `imem_req_valid` and `imem_addr` are decoded from registered state and the PC only.
- `imem_req_valid` does not depend combinationally on `imem_req_ready`.

## Test plan
- **Reset and basic fetch:** release reset with `RESET_PC = 0`, 1-cycle memory returning 32'h01190933 at address 0 and 32'hfffb8b93 at address 4. Required:
  - Addresses 0 then 4.
  - `id_inst = 01190933`, `id_opcode = 0110011`, `id_pc = 0`, `id_pc_plus4 = 4`.
  - Then `id_inst = fffb8b93`, `id_opcode = 0010011`, `id_pc = 4`.
  - `id_valid` alternates 1/0.
- **Stall with skid:** assert `stall` for 4 cycles while 32'h0082a223 is in IF/ID and 32'h0002a303 returns. Required:
  - IF/ID frozen during the stall.
  - No new request while in `FULL`.
  - `0002a303` appears in IF/ID the cycle after `stall` drops.
- **Redirect in WAIT:** `redirect_pc = 32'h0000_002C` while a request to 0x8 is outstanding; the late response is 32'hDEADBEEF. Required:
  - `id_valid = 0`.
  - DEADBEEF never reaches IF/ID.
  - The next `imem_addr` is 0x2C.
- **Simultaneous events:**
  - Redirect to 0x100 together with `stall = 1` and a response: flush wins, `id_valid = 0`, fetch resumes at 0x100.
  - Redirect with `redirect_pc = 32'h103`: fetch address is 0x100.
- **Wrap-around and backpressure:**
  - `RESET_PC = 32'hFFFF_FFFC`, `imem_req_ready` low for 3 cycles. Required: `imem_addr` holds FFFF_FFFC, then after fetch `id_pc_plus4 = 0` and the next `imem_addr = 0`.
  - Assert `rst` while in `WAIT`. Required: all outputs return to reset values asynchronously, and the next request goes to `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC, single-outstanding imem handshake,
// one-entry skid buffer and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [6:0]  id_opcode,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  typedef enum logic [1:0] {FETCH, WAIT, FULL, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [6:0]  id_opcode_q, id_opcode_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

  logic        load_en;
  logic [31:0] load_inst;
  logic [31:0] load_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0;
      skid_inst_q   <= NOP_INST;
      skid_pc_q     <= 32'h0;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_opcode_q   <= NOP_INST[6:0];
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_opcode_q   <= id_opcode_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_opcode_d   = id_opcode_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    load_en       = 1'b0;
    load_inst     = imem_rsp_data;
    load_pc       = req_pc_q;

    case (state_q)
      FETCH: begin
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (stall) begin
            skid_inst_d = imem_rsp_data;
            skid_pc_d   = req_pc_q;
            state_d     = FULL;
          end else begin
            load_en = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FULL: begin
        if (!stall) begin
          load_en   = 1'b1;
          load_inst = skid_inst_q;
          load_pc   = skid_pc_q;
          state_d   = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // IF/ID advances whenever decode is not stalled; no new instruction means a bubble
    if (!stall) begin
      if (load_en) begin
        id_valid_d    = 1'b1;
        id_inst_d     = load_inst;
        id_opcode_d   = load_inst[6:0];
        id_pc_d       = load_pc;
        id_pc_plus4_d = load_pc + 32'd4;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
      end
    end

    // Redirect overrides everything; an already-issued request must be drained
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      case (state_q)
        FETCH:   state_d = imem_req_ready ? DRAIN : FETCH;
        WAIT:    state_d = imem_rsp_valid ? FETCH : DRAIN;
        FULL:    state_d = FETCH;
        DRAIN:   state_d = imem_rsp_valid ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req_valid = (state_q == FETCH) && !rst;
  assign imem_addr      = pc_q;
  assign id_valid       = id_valid_q;
  assign id_inst        = id_inst_q;
  assign id_opcode      = id_opcode_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against a program-order fetch/retire model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc_plus4;
  logic [6:0]  id_opcode;

  logic        w_rst, w_ready, w_rsp_valid, w_req_valid, w_id_valid;
  logic [31:0] w_rsp_data, w_addr, w_id_inst, w_id_pc, w_id_plus4;
  logic [6:0]  w_id_opcode;

  int n_checks;
  int n_errors;

  logic [31:0] memw [logic [31:0]];
  bit          mem_auto;
  bit          pend;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;
  int unsigned lat;

  fetch_stage u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_inst(id_inst), .id_opcode(id_opcode),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_id_valid), .id_inst(w_id_inst), .id_opcode(w_id_opcode),
    .id_pc(w_id_pc), .id_pc_plus4(w_id_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock; the memory model answers an accepted request after 'lat' extra cycles
  task automatic tick();
    bit          fire;
    logic [31:0] faddr;
    #1;
    fire  = imem_req_valid && imem_req_ready;
    faddr = imem_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (fire) begin
        pend      = 1'b1;
        pend_addr = faddr;
        pend_cnt  = lat;
      end
      if (pend && pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_rd(pend_addr);
        pend           = 1'b0;
      end else begin
        imem_rsp_valid = 1'b0;
        if (pend) pend_cnt--;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; w_rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    mem_auto = 1'b0; pend = 1'b0; lat = 0;
    #2;
    n_checks++;
    if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4} !== {1'b0, NOP, 7'b0010011, 32'h0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_id: got v=%b inst=%h op=%b pc=%h pc4=%h", id_valid, id_inst, id_opcode, id_pc, id_pc_plus4);
    end
    imem_req_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({imem_req_valid, imem_addr} !== {1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_req: got valid=%b addr=%h want 0/00000000", imem_req_valid, imem_addr);
    end
    n_checks++;
    if ({w_req_valid, w_addr, w_id_valid} !== {1'b0, 32'hFFFF_FFFC, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_wrap: got valid=%b addr=%h idv=%b", w_req_valid, w_addr, w_id_valid);
    end
    rst = 1'b0; w_rst = 1'b0;
  endtask

  task automatic test_basic();
    memw[32'h0] = 32'h0119_0933;
    memw[32'h4] = 32'hfffb_8b93;
    memw[32'h8] = 32'h0082_a223;
    memw[32'hC] = 32'h0002_a303;
    imem_req_ready = 1'b1; lat = 0; mem_auto = 1'b1;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL basic_req0: got valid=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
    tick();
    n_checks++;
    if ({imem_req_valid, id_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_wait: got req_valid=%b id_valid=%b want 0/0", imem_req_valid, id_valid);
    end
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4} !== {1'b1, 32'h0119_0933, 7'b0110011, 32'h0, 32'h4}) begin
      n_errors++;
      $display("FAIL basic_id0: got v=%b inst=%h op=%b pc=%h pc4=%h", id_valid, id_inst, id_opcode, id_pc, id_pc_plus4);
    end
    n_checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h4}) begin
      n_errors++;
      $display("FAIL basic_req4: got valid=%b addr=%h want 1/00000004", imem_req_valid, imem_addr);
    end
    tick();
    n_checks++;
    if ({id_valid, id_inst} !== {1'b0, NOP}) begin
      n_errors++;
      $display("FAIL basic_bubble: got v=%b inst=%h want 0/%h", id_valid, id_inst, NOP);
    end
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4} !== {1'b1, 32'hfffb_8b93, 7'b0010011, 32'h4, 32'h8}) begin
      n_errors++;
      $display("FAIL basic_id4: got v=%b inst=%h op=%b pc=%h pc4=%h", id_valid, id_inst, id_opcode, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_stall();
    tick();
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_pc} !== {1'b1, 32'h0082_a223, 32'h8}) begin
      n_errors++;
      $display("FAIL stall_pre: got v=%b inst=%h pc=%h", id_valid, id_inst, id_pc);
    end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4, imem_req_valid} !==
          {1'b1, 32'h0082_a223, 7'b0100011, 32'h8, 32'hC, 1'b0}) begin
        n_errors++;
        $display("FAIL stall_hold%0d: got v=%b inst=%h op=%b pc=%h pc4=%h req=%b", k,
                 id_valid, id_inst, id_opcode, id_pc, id_pc_plus4, imem_req_valid);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4} !== {1'b1, 32'h0002_a303, 7'b0000011, 32'hC, 32'h10}) begin
      n_errors++;
      $display("FAIL stall_release: got v=%b inst=%h op=%b pc=%h pc4=%h", id_valid, id_inst, id_opcode, id_pc, id_pc_plus4);
    end
    n_checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h10}) begin
      n_errors++;
      $display("FAIL stall_next_req: got valid=%b addr=%h want 1/00000010", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    memw[32'h8] = 32'hDEAD_BEEF; memw[32'h2C] = 32'h00c5_8533; lat = 2;
    n_checks++;
    if ({id_valid, id_inst, imem_addr} !== {1'b0, NOP, 32'h8}) begin
      n_errors++;
      $display("FAIL redir_to8: got v=%b inst=%h addr=%h", id_valid, id_inst, imem_addr);
    end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h2C;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({id_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b0, 32'h2C}) begin
      n_errors++;
      $display("FAIL redir_wait: got v=%b req=%b addr=%h want 0/0/0000002c", id_valid, imem_req_valid, imem_addr);
    end
    tick();
    lat = 0;
    tick();
    n_checks++;
    if ({imem_req_valid, imem_addr, id_valid, id_inst} !== {1'b1, 32'h2C, 1'b0, NOP}) begin
      n_errors++;
      $display("FAIL redir_drained: got req=%b addr=%h v=%b inst=%h", imem_req_valid, imem_addr, id_valid, id_inst);
    end
    tick();
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4} !== {1'b1, 32'h00c5_8533, 7'b0110011, 32'h2C, 32'h30}) begin
      n_errors++;
      $display("FAIL redir_target: got v=%b inst=%h op=%b pc=%h pc4=%h", id_valid, id_inst, id_opcode, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_simultaneous();
    memw[32'h100] = 32'h0400_0513;
    tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if ({id_valid, id_inst, imem_req_valid, imem_addr} !== {1'b0, NOP, 1'b1, 32'h100}) begin
      n_errors++;
      $display("FAIL simul_flush: got v=%b inst=%h req=%b addr=%h", id_valid, id_inst, imem_req_valid, imem_addr);
    end
    tick();
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_pc, id_pc_plus4} !== {1'b1, 32'h0400_0513, 32'h100, 32'h104}) begin
      n_errors++;
      $display("FAIL simul_resume: got v=%b inst=%h pc=%h pc4=%h", id_valid, id_inst, id_pc, id_pc_plus4);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({id_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b0, 32'h100}) begin
      n_errors++;
      $display("FAIL simul_align: got v=%b req=%b addr=%h want 0/0/00000100", id_valid, imem_req_valid, imem_addr);
    end
    tick();
    n_checks++;
    if ({imem_req_valid, imem_addr, id_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_errors++;
      $display("FAIL simul_refetch: got req=%b addr=%h v=%b", imem_req_valid, imem_addr, id_valid);
    end
    tick();
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_pc} !== {1'b1, 32'h0400_0513, 32'h100}) begin
      n_errors++;
      $display("FAIL simul_again: got v=%b inst=%h pc=%h", id_valid, id_inst, id_pc);
    end
  endtask

  task automatic test_wrap();
    w_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({w_req_valid, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
        n_errors++;
        $display("FAIL wrap_hold%0d: got valid=%b addr=%h want 1/fffffffc", k, w_req_valid, w_addr);
      end
    end
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0; w_rsp_valid = 1'b1; w_rsp_data = 32'h0010_0093;
    tick();
    w_rsp_valid = 1'b0;
    n_checks++;
    if ({w_id_valid, w_id_inst, w_id_opcode, w_id_pc, w_id_plus4} !== {1'b1, 32'h0010_0093, 7'b0010011, 32'hFFFF_FFFC, 32'h0}) begin
      n_errors++;
      $display("FAIL wrap_id: got v=%b inst=%h op=%b pc=%h pc4=%h", w_id_valid, w_id_inst, w_id_opcode, w_id_pc, w_id_plus4);
    end
    n_checks++;
    if ({w_req_valid, w_addr} !== {1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL wrap_next: got valid=%b addr=%h want 1/00000000", w_req_valid, w_addr);
    end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1'b1; mem_auto = 1'b0; imem_rsp_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4, imem_req_valid, imem_addr} !==
        {1'b0, NOP, 7'b0010011, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL rstmid_async: got v=%b inst=%h op=%b pc=%h pc4=%h req=%b addr=%h",
               id_valid, id_inst, id_opcode, id_pc, id_pc_plus4, imem_req_valid, imem_addr);
    end
    tick();
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL rstmid_req: got valid=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
    tick();
    imem_rsp_valid = 1'b0;
    n_checks++;
    if ({id_valid, id_inst, imem_req_valid} !== {1'b0, NOP, 1'b1}) begin
      n_errors++;
      $display("FAIL rstmid_stale: got v=%b inst=%h req=%b", id_valid, id_inst, imem_req_valid);
    end
    pend = 1'b0; mem_auto = 1'b1; imem_req_ready = 1'b1; lat = 0;
    tick();
    tick();
    n_checks++;
    if ({id_valid, id_inst, id_pc, id_pc_plus4} !== {1'b1, mem_rd(32'h0), 32'h0, 32'h4}) begin
      n_errors++;
      $display("FAIL rstmid_refetch: got v=%b inst=%h pc=%h pc4=%h", id_valid, id_inst, id_pc, id_pc_plus4);
    end
  endtask

  // Every instruction reaching IF/ID must follow program order from the last
  // redirect target; fetch addresses follow the same stream independently.
  task automatic test_random();
    logic [31:0]  exp_pc, fetch_exp, tgt, prev_tgt, w;
    logic [103:0] snap;
    bit           prev_stall, prev_redir;
    int           entries;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    tick();
    rst = 1'b0; pend = 1'b0; imem_rsp_valid = 1'b0; mem_auto = 1'b1;
    #1;
    exp_pc = 32'h0; fetch_exp = 32'h0; prev_tgt = 32'h0;
    prev_stall = 1'b0; prev_redir = 1'b0; entries = 0; snap = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_redir) begin
        n_checks++;
        if ({id_valid, id_inst, imem_addr} !== {1'b0, NOP, prev_tgt}) begin
          n_errors++;
          $display("FAIL rand_flush@%0d: got v=%b inst=%h addr=%h want addr %h", cyc, id_valid, id_inst, imem_addr, prev_tgt);
        end
      end else if (prev_stall) begin
        n_checks++;
        if ({id_valid, id_inst, id_opcode, id_pc, id_pc_plus4} !== snap) begin
          n_errors++;
          $display("FAIL rand_frozen@%0d: got %h want %h", cyc, {id_valid, id_inst, id_opcode, id_pc, id_pc_plus4}, snap);
        end
      end else if (id_valid) begin
        w = mem_rd(exp_pc);
        n_checks++;
        if ({id_inst, id_opcode, id_pc, id_pc_plus4} !== {w, w[6:0], exp_pc, exp_pc + 32'd4}) begin
          n_errors++;
          $display("FAIL rand_entry@%0d: got inst=%h op=%b pc=%h pc4=%h want pc %h inst %h", cyc,
                   id_inst, id_opcode, id_pc, id_pc_plus4, exp_pc, w);
        end
        exp_pc  = exp_pc + 32'd4;
        entries++;
      end else begin
        n_checks++;
        if (id_inst !== NOP) begin
          n_errors++;
          $display("FAIL rand_bubble@%0d: got inst=%h want %h", cyc, id_inst, NOP);
        end
      end
      snap = {id_valid, id_inst, id_opcode, id_pc, id_pc_plus4};

      stall          = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 32'($urandom_range(0, 1023));
      lat            = $urandom_range(0, 2);
      tgt            = {redirect_pc[31:2], 2'b00};

      if (imem_req_valid && imem_req_ready) begin
        n_checks++;
        if ({imem_addr, pend} !== {fetch_exp, 1'b0}) begin
          n_errors++;
          $display("FAIL rand_fetch@%0d: got addr=%h outstanding=%b want %h/0", cyc, imem_addr, pend, fetch_exp);
        end
        fetch_exp = fetch_exp + 32'd4;
      end
      if (redirect_valid) begin
        fetch_exp = tgt;
        exp_pc    = tgt;
      end
      prev_stall = stall;
      prev_redir = redirect_valid;
      prev_tgt   = tgt;
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if (entries < 100) begin
      n_errors++;
      $display("FAIL rand_progress: got %0d instructions want at least 100", entries);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
